// File: rtl/flash_rom_prefetch_if.sv
// Host-side and flash-side signals of the ROM prefetch buffer.
// The slave modport is the prefetch buffer's view; master is the surrounding system's view.
interface flash_rom_prefetch_if;
    logic [21:0] ihost_addr;
    logic        ihost_req;
    logic        ohost_ack;
    logic [15:0] ohost_dout;
    logic        iinvalidate;
    logic [22:0] ofl_addr;
    logic        ofl_req;
    logic        ifl_ack;
    logic [15:0] ifl_dout;

    modport slave (
        input  ihost_addr, ihost_req, iinvalidate, ifl_ack, ifl_dout,
        output ohost_ack, ohost_dout, ofl_addr, ofl_req
    );

    modport master (
        output ihost_addr, ihost_req, iinvalidate, ifl_ack, ifl_dout,
        input  ohost_ack, ohost_dout, ofl_addr, ofl_req
    );
endinterface

// File: rtl/flash_rom_prefetch.sv
// One-line prefetch buffer between the cartridge ROM host port and the flash word reader.
// A miss refills the whole line from its base upward, one flash word at a time.
// Words already in the line are served with one cycle of latency.
module flash_rom_prefetch #(
    parameter int unsigned LINE_WORDS     = 4,
    parameter int unsigned STARTUP_CYCLES = 48
) (
    input logic                 iclk,
    input logic                 ireset,
    flash_rom_prefetch_if.slave bus
);

    localparam int unsigned IdxW = $clog2(LINE_WORDS);
    localparam int unsigned TagW = 22 - IdxW;
    localparam int unsigned CntW = $clog2(STARTUP_CYCLES + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(LINE_WORDS - 1);

    localparam logic [1:0] StStartup  = 2'd0;
    localparam logic [1:0] StIdle     = 2'd1;
    localparam logic [1:0] StFillReq  = 2'd2;
    localparam logic [1:0] StFillWait = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [TagW-1:0]       tag_q, tag_d;
    logic [LINE_WORDS-1:0] valid_q, valid_d;
    logic [IdxW-1:0]       fill_idx_q, fill_idx_d;
    logic                  kill_q, kill_d;
    logic                  host_ack_q, host_ack_d;
    logic [15:0]           host_dout_q, host_dout_d;
    logic                  fl_req_q, fl_req_d;
    logic [22:0]           fl_addr_q, fl_addr_d;
    logic [15:0]           line_q [LINE_WORDS];
    logic                  line_we;

    logic [TagW-1:0] host_tag;
    logic [IdxW-1:0] host_idx;
    logic            pending, tag_match, hit, fl_done, fill_match, kill_now;

    assign host_tag   = bus.ihost_addr[21:IdxW];
    assign host_idx   = bus.ihost_addr[IdxW-1:0];
    assign pending    = bus.ihost_req != host_ack_q;
    assign tag_match  = host_tag == tag_q;
    assign fl_done    = bus.ifl_ack == fl_req_q;
    assign fill_match = pending && tag_match && (host_idx == fill_idx_q);
    assign kill_now   = kill_q || bus.iinvalidate;
    // Line contents are stale once an invalidate is seen, so no hits while one is in progress.
    assign hit = pending && tag_match && valid_q[host_idx] && !kill_now
                 && (state_q != StStartup);

    // Next-state: host responses, line fill sequencing and invalidation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        fill_idx_d  = fill_idx_q;
        kill_d      = kill_q;
        host_ack_d  = host_ack_q;
        host_dout_d = host_dout_q;
        fl_req_d    = fl_req_q;
        fl_addr_d   = fl_addr_q;
        line_we     = 1'b0;

        if (hit) begin
            host_ack_d  = bus.ihost_req;
            host_dout_d = line_q[host_idx];
        end

        case (state_q)
            StStartup: begin
                if (bus.iinvalidate) valid_d = '0;
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StIdle: begin
                if (bus.iinvalidate) valid_d = '0;
                if (pending && !hit) begin
                    tag_d      = host_tag;
                    valid_d    = '0;
                    fill_idx_d = '0;
                    state_d    = StFillReq;
                end
            end
            StFillReq: begin
                // No transaction is outstanding here, so a kill can finish immediately.
                if (kill_now) begin
                    valid_d = '0;
                    kill_d  = 1'b0;
                    state_d = StIdle;
                end else if (fl_done) begin
                    fl_addr_d = {tag_q, fill_idx_q, 1'b0};
                    fl_req_d  = ~fl_req_q;
                    state_d   = StFillWait;
                end
            end
            StFillWait: begin
                if (bus.iinvalidate) kill_d = 1'b1;
                if (fl_done) begin
                    if (kill_now) begin
                        valid_d = '0;
                        kill_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        line_we              = 1'b1;
                        valid_d[fill_idx_q]  = 1'b1;
                        // Forwarding the arriving word wins over a hit; the hit retries next cycle.
                        if (fill_match) begin
                            host_ack_d  = bus.ihost_req;
                            host_dout_d = bus.ifl_dout;
                        end
                        if (fill_idx_q == LastIdx) begin
                            state_d = StIdle;
                        end else begin
                            fill_idx_d = fill_idx_q + 1'b1;
                            state_d    = StFillReq;
                        end
                    end
                end
            end
            default: state_d = StStartup;
        endcase
    end

    // Control state; reset drops any fill in flight since the flash side resets too.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q     <= StStartup;
            cnt_q       <= CntW'(STARTUP_CYCLES);
            tag_q       <= '0;
            valid_q     <= '0;
            fill_idx_q  <= '0;
            kill_q      <= 1'b0;
            host_ack_q  <= bus.ihost_req;
            host_dout_q <= '0;
            fl_req_q    <= 1'b0;
            fl_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            fill_idx_q  <= fill_idx_d;
            kill_q      <= kill_d;
            host_ack_q  <= host_ack_d;
            host_dout_q <= host_dout_d;
            fl_req_q    <= fl_req_d;
            fl_addr_q   <= fl_addr_d;
        end
    end

    // Line data storage; contents are qualified by valid_q so no reset is needed.
    always_ff @(posedge iclk) begin
        if (line_we && !ireset) line_q[fill_idx_q] <= bus.ifl_dout;
    end

    assign bus.ohost_ack  = host_ack_q;
    assign bus.ohost_dout = host_dout_q;
    assign bus.ofl_req    = fl_req_q;
    assign bus.ofl_addr   = fl_addr_q;

endmodule

// File: tb/tb_flash_rom_prefetch.sv
// Scoreboard bench for flash_rom_prefetch: directed timing scenarios plus random reads
// against a flash model with random latency and a fixed ROM image function.
module tb_flash_rom_prefetch;

    localparam int unsigned LINE_WORDS     = 4;
    localparam int unsigned STARTUP_CYCLES = 48;

    logic iclk   = 1'b0;
    logic ireset = 1'b1;
    flash_rom_prefetch_if bus();

    flash_rom_prefetch #(
        .LINE_WORDS    (LINE_WORDS),
        .STARTUP_CYCLES(STARTUP_CYCLES)
    ) dut (
        .iclk  (iclk),
        .ireset(ireset),
        .bus   (bus)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] sb_q[$];
    logic [22:0] fl_log[$];
    int          req_cyc[$];
    int          done_cyc[$];
    int          issue_cyc;
    int          rel_cyc;
    int          ac;
    int          base;
    logic [21:0] raddr;

    // ROM image: word address -> data; word 0x10 holds 0x1234.
    function automatic logic [15:0] mem_word(input logic [21:0] w);
        logic [21:0] t;
        t = (w - 22'h10) * 22'h2F1;
        return t[15:0] ^ 16'h1234 ^ {10'h0, w[21:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < fl_log.size()) ? 32'(fl_log[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic int done_at(input int i);
        return (i < done_cyc.size()) ? done_cyc[i] : -100;
    endfunction

    function automatic int req_at(input int i);
        return (i < req_cyc.size()) ? req_cyc[i] : -100;
    endfunction

    // Flash controller model: one word per toggle request, random 6..20 cycle latency.
    initial begin
        logic        req_seen;
        logic        busy;
        int          lat;
        logic [22:0] cur;
        req_seen = 1'b0;
        busy     = 1'b0;
        lat      = 0;
        cur      = '0;
        bus.ifl_ack  = 1'b0;
        bus.ifl_dout = '0;
        forever begin
            @(negedge iclk);
            if (ireset) begin
                busy        = 1'b0;
                req_seen    = 1'b0;
                bus.ifl_ack = 1'b0;
                while (done_cyc.size() < fl_log.size()) done_cyc.push_back(-1);
            end else begin
                if (busy) begin
                    if (lat > 0) begin
                        lat--;
                    end else begin
                        bus.ifl_dout = mem_word(cur[22:1]);
                        bus.ifl_ack  = ~bus.ifl_ack;
                        busy         = 1'b0;
                        done_cyc.push_back(cyc);
                    end
                end
                if (bus.ofl_req != req_seen) begin
                    req_seen = bus.ofl_req;
                    chk("fl_no_overlap", 32'(busy), 32'd0);
                    chk("fl_addr_even", 32'(bus.ofl_addr[0]), 32'd0);
                    busy = 1'b1;
                    lat  = int'($urandom_range(5, 19));
                    cur  = bus.ofl_addr;
                    fl_log.push_back(bus.ofl_addr);
                    req_cyc.push_back(cyc);
                end
            end
        end
    end

    // Monitor: every host ack toggle outside reset pops one expected word.
    initial begin
        logic        pa;
        logic [15:0] e;
        @(negedge iclk);
        pa = bus.ohost_ack;
        forever begin
            @(negedge iclk);
            if (ireset) begin
                pa = bus.ohost_ack;
            end else if (bus.ohost_ack != pa) begin
                pa = bus.ohost_ack;
                if (sb_q.size() == 0) begin
                    fail_now("spurious_host_ack");
                end else begin
                    e = sb_q.pop_front();
                    chk("host_dout", 32'(bus.ohost_dout), 32'(e));
                end
            end
        end
    end

    task automatic issue(input logic [21:0] a);
        bus.ihost_addr = a;
        sb_q.push_back(mem_word(a));
        bus.ihost_req = ~bus.ihost_req;
        issue_cyc     = cyc;
    endtask

    task automatic wait_ack(output int c);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge iclk);
            if (bus.ohost_ack == bus.ihost_req) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) fail_now("host_ack_timeout");
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 400; i++) begin
            if (fl_log.size() >= n) break;
            @(negedge iclk);
        end
        if (fl_log.size() < n) fail_now("flash_req_timeout");
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 600 && quiet < 5; i++) begin
            @(negedge iclk);
            if (done_cyc.size() == fl_log.size()) quiet++;
            else quiet = 0;
        end
        if (quiet < 5) fail_now("flash_idle_timeout");
    endtask

    task automatic pulse_inv();
        bus.iinvalidate = 1'b1;
        @(negedge iclk);
        bus.iinvalidate = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ihost_addr  = '0;
        bus.ihost_req   = 1'b0;
        bus.iinvalidate = 1'b0;
        repeat (4) @(negedge iclk);
        chk("rst_host_ack", 32'(bus.ohost_ack), 32'(bus.ihost_req));
        chk("rst_host_dout", 32'(bus.ohost_dout), 32'd0);
        chk("rst_fl_req", 32'(bus.ofl_req), 32'd0);
        chk("rst_fl_addr", 32'(bus.ofl_addr), 32'd0);
        ireset  = 1'b0;
        rel_cyc = cyc;

        // Cold miss after startup: full line fill from the line base.
        repeat (5) @(negedge iclk);
        issue(22'h10);
        wait_ack(ac);
        chk("t1_dout_1234", 32'(bus.ohost_dout), 32'h1234);
        chk("t1_ack_with_word0", 32'(ac), 32'(done_at(0) + 1));
        wait_idle();
        chk("t1_startup_gap", 32'(req_at(0) - rel_cyc >= int'(STARTUP_CYCLES)), 32'd1);
        for (int k = 0; k < 4; k++) chk("t1_fill_addr", log_at(k), 32'(32'h20 + 2 * k));
        chk("t1_fill_len", 32'(fl_log.size()), 32'd4);

        // Hits in the filled line: one-cycle latency, no flash traffic.
        base = fl_log.size();
        for (int k = 1; k < 4; k++) begin
            issue(22'h10 + 22'(k));
            wait_ack(ac);
            chk("t2_hit_latency", 32'(ac - issue_cyc), 32'd1);
        end
        chk("t2_no_flash_req", 32'(fl_log.size()), 32'(base));

        // Word 3 requested while word 1 is in flight: served as word 3 arrives.
        wait_idle();
        pulse_inv();
        base = fl_log.size();
        issue(22'h10);
        wait_ack(ac);
        wait_log(base + 2);
        issue(22'h13);
        wait_ack(ac);
        chk("t3_ack_with_word3", 32'(ac), 32'(done_at(base + 3) + 1));

        // Other-line request during a fill waits for the fill, then misses.
        wait_idle();
        pulse_inv();
        base = fl_log.size();
        issue(22'h10);
        wait_ack(ac);
        issue(22'h40);
        wait_ack(ac);
        chk("t3_old_fill_done", log_at(base + 3), 32'h26);
        chk("t3_new_line_addr", log_at(base + 4), 32'h80);
        chk("t3_ack_new_word0", 32'(ac), 32'(done_at(base + 4) + 1));

        // Invalidate while word 2 is in flight: its data is dropped and the line refetched.
        wait_idle();
        pulse_inv();
        base = fl_log.size();
        issue(22'h10);
        wait_ack(ac);
        wait_log(base + 3);
        pulse_inv();
        issue(22'h12);
        wait_ack(ac);
        chk("t4_killed_word2", log_at(base + 2), 32'h24);
        chk("t4_refill_base", log_at(base + 3), 32'h20);
        chk("t4_ack_new_word2", 32'(ac), 32'(done_at(base + 5) + 1));

        // Reset mid-fill with a host request pending.
        wait_idle();
        pulse_inv();
        issue(22'h30);
        wait_ack(ac);
        issue(22'h33);
        repeat (2) @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);
        chk("t5_ack_eq_req", 32'(bus.ohost_ack), 32'(bus.ihost_req));
        chk("t5_fl_req", 32'(bus.ofl_req), 32'd0);
        chk("t5_host_dout", 32'(bus.ohost_dout), 32'd0);
        @(negedge iclk);
        ireset = 1'b0;
        sb_q.delete();
        rel_cyc = cyc;
        base    = fl_log.size();
        issue(22'h30);
        wait_ack(ac);
        chk("t5_refill_addr", log_at(base), 32'h60);
        chk("t5_startup_gap", 32'(req_at(base) - rel_cyc >= int'(STARTUP_CYCLES)), 32'd1);

        // Random sequential and jump reads with occasional invalidates.
        raddr = 22'h100;
        for (int i = 0; i < 1000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60)      raddr = raddr + 22'd1;
            else if (r < 90) raddr = 22'($urandom_range(0, 1023));
            else             raddr = 22'($urandom);
            if ($urandom_range(0, 99) < 3) pulse_inv();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge iclk);
            issue(raddr);
            wait_ack(ac);
        end

        wait_idle();
        repeat (5) @(negedge iclk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
